// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RV64I memory stage.
// Contents: FSM state type, exception code type, load/store opcodes, funct3 size
// encodings, and helpers for the byte-enable mask and the natural-alignment test.
package riscv_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      EXC_NONE     = 2'd0,
      EXC_MISALIGN = 2'd1,
      EXC_ACCESS   = 2'd2,
      EXC_ILLEGAL  = 2'd3
   } lsu_exc_e;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // funct3[1:0] is the log2 access size for every legal load/store.
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = addr_lo[0];
         2'd2:    bad = |addr_lo[1:0];
         default: bad = |addr_lo;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering for the memory stage.
// Ports:
//   addr_lo    in   low three address bits of the access
//   funct3     in   access size/sign
//   rs2        in   raw store data
//   rdata      in   aligned doubleword returned by memory
//   be         out  byte enables (size mask shifted to the addressed lane)
//   wdata      out  store data shifted to the addressed lane
//   load_data  out  addressed field of rdata, sign/zero-extended to 64 bits
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [2:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [63:0] rs2,
   input  logic [63:0] rdata,
   output logic [7:0]  be,
   output logic [63:0] wdata,
   output logic [63:0] load_data
);

   logic [5:0]  shamt;
   logic [63:0] shifted;

   assign shamt   = {addr_lo, 3'b000};
   assign be      = size_mask(funct3[1:0]) << addr_lo;
   assign wdata   = rs2 << shamt;
   assign shifted = rdata >> shamt;

   always_comb begin
      case (funct3)
         F3_B:    load_data = {{56{shifted[7]}}, shifted[7:0]};
         F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
         F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
         F3_BU:   load_data = {56'd0, shifted[7:0]};
         F3_HU:   load_data = {48'd0, shifted[15:0]};
         F3_WU:   load_data = {32'd0, shifted[31:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/riscv_lsu_stage.sv
// RV64I memory stage. Classifies each EX3 instruction as load, store or
// pass-through, issues one outstanding data-memory request per load/store, then
// aligns/extends the response into a registered result for writeback.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ex3_*                           registered EX3 outputs (held while lsu_stall)
//   lsu_stall                       upstream hold while an access is in flight
//   dmem_req_* / dmem_rsp_*         valid/ready request channel and response
//   mem_pc/inst/rd_addr/result      registered result to writeback
//   mem_rd_we, mem_exc, mem_valid   writeback enable, exception code, valid
module riscv_lsu_stage
   import riscv_lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] ex3_pc,
   input  logic [31:0] ex3_inst,
   input  logic [63:0] ex3_alu_result,
   input  logic [63:0] ex3_rs2_data,
   input  logic [4:0]  ex3_rd_addr,
   input  logic [2:0]  ex3_funct3,
   input  logic        ex3_valid,
   output logic        lsu_stall,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_req_we,
   output logic [63:0] dmem_req_addr,
   output logic [63:0] dmem_req_wdata,
   output logic [7:0]  dmem_req_be,
   input  logic        dmem_rsp_valid,
   input  logic [63:0] dmem_rsp_rdata,
   input  logic        dmem_rsp_err,
   output logic [63:0] mem_pc,
   output logic [31:0] mem_inst,
   output logic [4:0]  mem_rd_addr,
   output logic [63:0] mem_result,
   output logic        mem_rd_we,
   output logic [1:0]  mem_exc,
   output logic        mem_valid
);

   lsu_state_e  state_q, state_d;
   lsu_exc_e    mem_exc_q, mem_exc_d;
   logic        mem_valid_q, mem_valid_d;
   logic        mem_rd_we_q, mem_rd_we_d;

   // Captured load/store; req fields derive from these so they stay stable in REQ.
   logic [63:0] op_pc_q, op_addr_q, op_rs2_q;
   logic [31:0] op_inst_q;
   logic [4:0]  op_rd_q;
   logic [2:0]  op_funct3_q;
   logic        op_store_q;

   logic        accept, is_load, is_store, is_mem, illegal, misalign;
   logic        cpl_ex3, cpl_dmem;
   logic [63:0] load_data;

   assign accept   = ex3_valid && (state_q == IDLE);
   assign is_load  = (ex3_inst[6:0] == OPC_LOAD);
   assign is_store = (ex3_inst[6:0] == OPC_STORE);
   assign is_mem   = is_load || is_store;
   assign illegal  = is_load ? (ex3_funct3 == 3'b111) : (is_store && ex3_funct3[2]);
   assign misalign = is_mem && misaligned(ex3_funct3[1:0], ex3_alu_result[2:0]);

   // Pass-through and faulting load/store retire straight from EX3; legal
   // memory ops retire when their response arrives.
   assign cpl_ex3  = accept && (!is_mem || illegal || misalign);
   assign cpl_dmem = (state_q == RSP) && dmem_rsp_valid;

   riscv_lsu_align u_align (
      .addr_lo   (op_addr_q[2:0]),
      .funct3    (op_funct3_q),
      .rs2       (op_rs2_q),
      .rdata     (dmem_rsp_rdata),
      .be        (dmem_req_be),
      .wdata     (dmem_req_wdata),
      .load_data (load_data)
   );

   always_comb begin
      state_d     = state_q;
      mem_valid_d = cpl_ex3 || cpl_dmem;
      mem_exc_d   = EXC_NONE;
      mem_rd_we_d = 1'b0;
      case (state_q)
         IDLE:    if (accept && is_mem && !illegal && !misalign) state_d = REQ;
         REQ:     if (dmem_req_ready) state_d = RSP;
         RSP:     if (dmem_rsp_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (cpl_ex3) begin
         if (illegal)       mem_exc_d = EXC_ILLEGAL;
         else if (misalign) mem_exc_d = EXC_MISALIGN;
         mem_rd_we_d = !is_mem && (ex3_rd_addr != 5'd0);
      end else if (cpl_dmem) begin
         if (dmem_rsp_err) mem_exc_d = EXC_ACCESS;
         mem_rd_we_d = !op_store_q && !dmem_rsp_err && (op_rd_q != 5'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_valid_q <= 1'b0;
         mem_exc_q   <= EXC_NONE;
         mem_rd_we_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_exc_q   <= mem_exc_d;
         mem_rd_we_q <= mem_rd_we_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_pc_q     <= ex3_pc;
         op_inst_q   <= ex3_inst;
         op_rd_q     <= ex3_rd_addr;
         op_addr_q   <= ex3_alu_result;
         op_rs2_q    <= ex3_rs2_data;
         op_funct3_q <= ex3_funct3;
         op_store_q  <= is_store;
      end
   end

   always_ff @(posedge clk) begin
      if (cpl_ex3) begin
         mem_pc      <= ex3_pc;
         mem_inst    <= ex3_inst;
         mem_rd_addr <= ex3_rd_addr;
         mem_result  <= ex3_alu_result;
      end else if (cpl_dmem) begin
         mem_pc      <= op_pc_q;
         mem_inst    <= op_inst_q;
         mem_rd_addr <= op_rd_q;
         mem_result  <= op_store_q ? op_addr_q : load_data;
      end
   end

   assign lsu_stall      = (state_q != IDLE);
   assign dmem_req_valid = (state_q == REQ);
   assign dmem_req_we    = op_store_q;
   assign dmem_req_addr  = {op_addr_q[63:3], 3'b000};
   assign mem_valid      = mem_valid_q;
   assign mem_exc        = mem_exc_q;
   assign mem_rd_we      = mem_rd_we_q;

endmodule

// File: doc/riscv_lsu_stage.md
# riscv_lsu_stage

Memory stage (stage 6 of 10) of the RV64I pipeline. It consumes the registered EX3 outputs, classifies each instruction as load, store or pass-through, and issues one outstanding 64-bit data-memory request per load/store over a valid/ready request channel. It then aligns and extends the response, and presents a registered result to the writeback side. It stalls the upstream pipeline while a memory access is in flight.

## Interface
- No parameters; XLEN fixed at 64.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ex3_pc  in  64  PC of incoming instruction
- ex3_inst  in  32  instruction word; opcode [6:0] selects load (0000011) / store (0100011) / pass-through
- ex3_alu_result  in  64  effective address (load/store) or ALU result (pass-through)
- ex3_rs2_data  in  64  store data
- ex3_rd_addr  in  5  destination register
- ex3_funct3  in  3  access size/sign
- ex3_valid  in  1  incoming instruction valid
- lsu_stall  out  1  upstream must hold EX3 outputs while high
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1 = store
- dmem_req_addr  out  64  {addr[63:3],3'b000}
- dmem_req_wdata  out  64  store data shifted to byte lanes
- dmem_req_be  out  8  byte enables
- dmem_rsp_valid  in  1  response (load data or store ack)
- dmem_rsp_rdata  in  64  aligned doubleword
- dmem_rsp_err  in  1  access fault
- mem_pc / mem_inst / mem_rd_addr  out  64/32/5  forwarded from accepted instruction
- mem_result  out  64  load data (extended) or ALU result
- mem_rd_we  out  1  writeback enable (loads, pass-through with rd≠0; never on exception/store)
- mem_exc  out  2  0 none, 1 misaligned, 2 access fault, 3 illegal funct3
- mem_valid  out  1  mem_* valid this cycle

## Operation
- FSM states IDLE, REQ, RSP.
- Accept: ex3_valid && state==IDLE.
- Pass-through accepted: mem_* loaded next edge, mem_result=ex3_alu_result; state stays IDLE.
- Load/store accepted, legal, aligned: capture op; state→REQ.
- Illegal funct3 (load 111, store 1xx): no request; mem_valid=1, mem_exc=3.
- Misaligned (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0): no request; mem_valid=1, mem_exc=1.
- REQ: dmem_req_valid=1 with all req fields stable until dmem_req_ready; handshake edge → RSP.
- RSP: on dmem_rsp_valid, mem_valid=1 next edge; state→IDLE.
  - Load: data = rdata >> (8·addr[2:0]), then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU); LD unchanged.
  - dmem_rsp_err=1: mem_exc=2, mem_rd_we=0.
  - Store: rdata ignored.
- Byte enables: size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]. wdata = rs2 << (8·addr[2:0]).
- dmem_rsp_valid in IDLE or REQ is ignored.
- mem_valid=0 in every cycle without a completion.

## Timing
- lsu_stall = (state != IDLE); decoded from state register only, no combinational path from dmem_*.
- Pass-through latency: 1 cycle; back-to-back issue, no bubbles.
- Load/store, minimum latency:
  - accept edge end of c0; c1 REQ with ready=1; c2 rsp_valid; c3 mem_valid=1.
  - lsu_stall high c1–c2; next EX3 instruction accepted at end of c3.
- Reset (any state, including mid-REQ/RSP):
  - state=IDLE; dmem_req_valid=0; mem_valid=0; mem_exc=0; mem_rd_we=0.
  - Data outputs not reset.
  - A response arriving after reset is ignored.

## Structure
- riscv_lsu_pkg holds:
  - lsu_state_e (IDLE/REQ/RSP)
  - lsu_exc_e (NONE/MISALIGN/ACCESS/ILLEGAL)
  - OPC_LOAD, OPC_STORE
  - funct3 size encodings
- Sub-module riscv_lsu_align (combinational): generates be/wdata from addr/size/rs2, and extracts/extends load data from rdata/addr/funct3.

## Test plan
- LW addr 0x1004, rdata 0x80000001_DEADBEEF → req addr 0x1000, be 0xF0; mem_result 0xFFFFFFFF_80000001, mem_rd_we=1, 3 cycles accept→mem_valid.
- SB addr 0x2003, rs2 0xAB → we=1, be 0x08, wdata[31:24]=0xAB; on ack mem_valid=1, mem_rd_we=0, mem_exc=0.
- LH addr 0x1001 → no dmem_req_valid; next cycle mem_valid=1, mem_exc=1, lsu_stall never high.
- LD with dmem_req_ready low 3 cycles → req fields stable, lsu_stall high throughout; completes 1 cycle after response.
- ALU, LBU (rdata byte=0x80 → 0x80), ALU back-to-back; then load with rsp_err → mem_exc=2, mem_rd_we=0; all results in order.
- rst_n asserted in RSP, released, stray rsp_valid → dmem_req_valid=0, mem_valid stays 0, next ALU op completes normally.
